fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. Returned words are buffered in a 2-entry queue, and the head entry is presented to IF/ID with its PC+4. The block honours pipeline stalls from the hazard unit and branch redirects from EXE.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit hold: IF/ID must not consume this cycle.
- branch_taken  in  1  one-cycle redirect request from EXE.
- branch_target  in  32  redirect address; bits [1:0] ignored (treated as 0).
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; bits [1:0] always 0.
- instruction  out  32  head-of-queue instruction, to IF/ID `instruction`.
- next_pc  out  32  head-of-queue fetch address + 4, to IF/ID `next_pc`.
- fetch_valid  out  1  queue non-empty; instruction/next_pc are meaningful.
- if_id_flush  out  1  combinational copy of branch_taken; top level ORs it into the IF/ID load enable and drives the IF/ID reset with it.

## Operation
- Registers:
  - pc: address of the next request.
  - Queue: 2 entries of {instr[31:0], npc[31:0]}, with head/tail pointers and count (0..2).
  - FSM: IDLE or REQ.
  - drop: 1 bit.
- Pop: pop = fetch_valid & ~stall & ~branch_taken. Advances the head and decrements count.
- IDLE:
  - imem_req = 0.
  - Goes to REQ on the next edge when (count < 2) or pop.
- REQ:
  - imem_req = 1 and imem_addr = pc.
  - Both are held stable until the imem_ack cycle.
  - A request is never withdrawn before ack, except by reset.
- Ack in REQ with drop = 0 and branch_taken = 0:
  - Push {imem_rdata, pc+4}; pc <= pc+4.
  - Stay in REQ if the post-push/pop count < 2, else go to IDLE.
- Ack with drop = 1 or branch_taken = 1:
  - Data is discarded and drop is cleared.
  - On branch_taken, pc <= branch_target & ~3.
  - Next state is REQ.
- Issue rule: at most 1 outstanding request. A request is only issued when the queue will have room for its response, so an ack never meets a full queue.
- branch_taken (any state):
  - Queue is flushed (count <= 0, pointers reset).
  - pc <= branch_target & ~3.
  - If a request is outstanding and imem_ack = 0 this cycle, drop <= 1 and the FSM stays in REQ on the old address until ack.
  - If in IDLE, the FSM goes to REQ.
- Simultaneous branch_taken + stall: branch wins and nothing is popped.
- Simultaneous push + pop: count unchanged.
- Addresses wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - FSM = IDLE, pc = RESET_PC, count = 0, drop = 0, queue entries = 0.
  - imem_req = 0, imem_addr = RESET_PC, fetch_valid = 0, instruction = 0, next_pc = 0.
  - if_id_flush follows branch_taken.
- First clock edge after reset release: IDLE→REQ. First imem_req is seen in cycle 1.
- Zero-wait memory (ack in the request cycle N): fetch_valid = 1 from cycle N+1.
  - Sustained throughput is 1 instruction/cycle with no stall.
- Wait-state memory: each ack after k wait cycles adds k cycles per fetch.
- Redirect: branch_taken in cycle N gives fetch_valid = 0 in N+1.
  - With no outstanding request, imem_addr = target in cycle N+1.
  - With an outstanding request, imem_addr = target in the cycle after the discarded ack.
- Reset mid-transaction: the outstanding request is abandoned. Memory must tolerate imem_req dropping without ack.

## Test plan
- Reset release, zero-wait memory returning rdata = addr ^ 0xE000_0000, stall = 0:
  - imem_addr = 0, 4, 8 … on consecutive cycles.
  - fetch_valid = 1 from cycle 2.
  - instruction/next_pc = 0xE000_0000/4, 0xE000_0004/8, …
- Stall held 4 cycles from the cycle the head is addr 0x8:
  - Queue fills to 2 and imem_req drops to 0.
  - Head stays 0xE000_0008/0xC.
  - After release, the sequence continues at 0xC with no loss or duplication.
- Memory with 2 wait cycles:
  - imem_req = 1 and imem_addr stable for 3 cycles per fetch.
  - fetch_valid pulses once per 3 cycles.
- branch_taken with branch_target = 0x103, no request outstanding:
  - if_id_flush = 1 the same cycle.
  - fetch_valid = 0 the next cycle; next imem_addr = 0x100; first next_pc = 0x104.
- branch_taken while a request to 0x10 waits (ack 2 cycles later):
  - The 0x10 data never appears on instruction.
  - The next request is 0x100.
- reset asserted mid-wait with no clock edge:
  - All outputs immediately take their reset values.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// and buffers returned words in a 2-entry queue whose head feeds IF/ID.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] instruction,
   output logic [31:0] next_pc,
   output logic        fetch_valid,
   output logic        if_id_flush
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] npc;
   } entry_t;

   typedef enum logic {IDLE, REQ} state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d, addr_d, pc_plus4, target;
   logic [CNT_W-1:0] count_q, count_d;
   logic             head_q, head_d, tail_q, tail_d;
   logic             drop_q, drop_d;
   logic             req_d;
   logic             pop, push;
   entry_t           queue_q [DEPTH];

   assign if_id_flush = branch_taken;
   assign target      = branch_target & ~XLEN'(3);
   assign pc_plus4    = pc_q + XLEN'(4);
   assign pop         = fetch_valid & ~stall & ~branch_taken;
   assign push        = (state_q == REQ) & imem_ack & ~drop_q & ~branch_taken;
   assign instruction = queue_q[head_q].instr;
   assign next_pc     = queue_q[head_q].npc;

   // Next-state, PC and queue bookkeeping
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      drop_d  = drop_q;

      if (pop) begin
         head_d  = ~head_q;
         count_d = count_d - CNT_W'(1);
      end
      if (push) begin
         tail_d  = ~tail_q;
         count_d = count_d + CNT_W'(1);
         pc_d    = pc_plus4;
      end
      if (branch_taken) begin
         count_d = '0;
         head_d  = 1'b0;
         tail_d  = 1'b0;
         pc_d    = target;
      end

      case (state_q)
         IDLE: begin
            if ((count_q != CNT_W'(DEPTH)) || pop || branch_taken) state_d = REQ;
         end
         REQ: begin
            if (imem_ack) begin
               drop_d = 1'b0;
               // only a real push can fill the queue; a discarded ack always re-issues
               if (push && (count_d == CNT_W'(DEPTH))) state_d = IDLE;
            end else if (branch_taken) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // the outstanding address is frozen until its ack, even across a redirect
      addr_d = ((state_q == REQ) && !imem_ack) ? imem_addr : pc_d;
      req_d  = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         imem_addr   <= RESET_PC;
         imem_req    <= 1'b0;
         count_q     <= '0;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         drop_q      <= 1'b0;
         fetch_valid <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) queue_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         imem_addr   <= addr_d;
         imem_req    <= req_d;
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         drop_q      <= drop_d;
         fetch_valid <= (count_d != '0);
         if (push) queue_q[tail_q] <= '{instr: imem_rdata, npc: pc_plus4};
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/branch/wait-state traffic,
// checked every cycle against a queue-based reference model.
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] XOR_KEY  = 32'hE000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instruction;
   logic [31:0] next_pc;
   logic        fetch_valid;
   logic        if_id_flush;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .instruction  (instruction),
      .next_pc      (next_pc),
      .fetch_valid  (fetch_valid),
      .if_id_flush  (if_id_flush)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;

   // reference model: pending-request flag, addresses, and a queue of {instr, npc}
   logic [31:0] m_pc, m_addr;
   bit          m_req, m_drop;
   logic [63:0] m_q[$];

   int unsigned mem_k    = 0;
   int unsigned wait_cnt = 0;
   bit          rand_mem = 1'b0;
   bit          watch_dropped = 1'b0;
   bit          dropped_seen  = 1'b0;
   int unsigned fv_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc     = RESET_PC;
      m_addr   = RESET_PC;
      m_req    = 1'b0;
      m_drop   = 1'b0;
      m_q.delete();
      wait_cnt = 0;
   endtask

   task automatic check_outputs();
      check("imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) check("imem_addr", imem_addr, m_addr);
      check("fetch_valid", 32'(fetch_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("instruction", instruction, m_q[0][63:32]);
         check("next_pc", next_pc, m_q[0][31:0]);
      end
      if (watch_dropped && fetch_valid && (instruction == (32'h10 ^ XOR_KEY))) dropped_seen = 1'b1;
   endtask

   task automatic model_step(input bit st, input bit br, input logic [31:0] tgt,
                             input bit ack, input logic [31:0] rdata);
      int          cnt;
      bit          pop, push, nreq, nd;
      logic [31:0] npc;
      cnt  = m_q.size();
      pop  = (cnt != 0) && !st && !br;
      push = m_req && ack && !m_drop && !br;
      npc  = m_pc;
      nd   = m_drop;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         m_q.push_back({rdata, m_pc + 32'd4});
         npc = m_pc + 32'd4;
      end
      if (br) begin
         m_q.delete();
         npc = tgt & 32'hFFFF_FFFC;
      end
      if (!m_req) begin
         nreq = br || (cnt < 2) || pop;
      end else if (ack) begin
         nreq = m_drop || br || (m_q.size() < 2);
         nd   = 1'b0;
      end else begin
         nreq = 1'b1;
         if (br) nd = 1'b1;
      end
      if (!(m_req && !ack)) m_addr = npc;
      wait_cnt = (m_req && !ack) ? wait_cnt + 1 : 0;
      if (ack && rand_mem) mem_k = $urandom_range(0, 3);
      m_pc   = npc;
      m_req  = nreq;
      m_drop = nd;
   endtask

   // one pipeline cycle: drive inputs, check outputs, clock, advance the model
   task automatic cycle(input bit st, input bit br, input logic [31:0] tgt);
      bit ack;
      ack           = m_req && (wait_cnt >= mem_k);
      stall         = st;
      branch_taken  = br;
      branch_target = tgt;
      imem_ack      = ack;
      imem_rdata    = ack ? (m_addr ^ XOR_KEY) : $urandom();
      #1;
      check_outputs();
      check("if_id_flush", 32'(if_id_flush), 32'(br));
      @(posedge clk);
      model_step(st, br, tgt, ack, imem_rdata);
      #1;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      model_reset();
      #2;
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_imem_addr", imem_addr, RESET_PC);
      check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst_instruction", instruction, 32'd0);
      check("rst_next_pc", next_pc, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // zero-wait streaming
      repeat (2) cycle(1'b0, 1'b0, 32'h0);
      check("t1_fv_cycle2", 32'(fetch_valid), 32'd1);
      check("t1_instr0", instruction, 32'hE000_0000);
      check("t1_npc0", next_pc, 32'h4);
      check("t1_addr4", imem_addr, 32'h4);
      repeat (2) cycle(1'b0, 1'b0, 32'h0);
      check("t2_head8", instruction, 32'hE000_0008);

      // stall fills the queue and parks the FSM
      repeat (2) cycle(1'b1, 1'b0, 32'h0);
      check("t2_req_idle", 32'(imem_req), 32'd0);
      check("t2_hold_instr", instruction, 32'hE000_0008);
      check("t2_hold_npc", next_pc, 32'hC);
      repeat (2) cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      check("t2_resume_instr", instruction, 32'hE000_000C);
      check("t2_resume_npc", next_pc, 32'h10);

      // two wait states per fetch
      mem_k = 2;
      cycle(1'b0, 1'b0, 32'h0);
      fv_seen = 0;
      for (int i = 0; i < 9; i++) begin
         if (fetch_valid) fv_seen++;
         cycle(1'b0, 1'b0, 32'h0);
      end
      check("t3_fv_pulses", fv_seen, 32'd3);

      // redirect with nothing outstanding (branch beats stall)
      mem_k = 0;
      repeat (3) cycle(1'b1, 1'b0, 32'h0);
      check("t4_idle_before", 32'(imem_req), 32'd0);
      cycle(1'b1, 1'b1, 32'h103);
      check("t4_fv_flushed", 32'(fetch_valid), 32'd0);
      check("t4_req", 32'(imem_req), 32'd1);
      check("t4_addr", imem_addr, 32'h100);
      cycle(1'b0, 1'b0, 32'h0);
      check("t4_first_npc", next_pc, 32'h104);
      check("t4_first_instr", instruction, 32'hE000_0100);

      // redirect while a request to 0x10 is waiting
      cycle(1'b0, 1'b1, 32'h10);
      check("t5_addr10", imem_addr, 32'h10);
      mem_k = 2;
      watch_dropped = 1'b1;
      cycle(1'b0, 1'b1, 32'h100);
      check("t5_addr_held", imem_addr, 32'h10);
      check("t5_fv0", 32'(fetch_valid), 32'd0);
      repeat (2) cycle(1'b0, 1'b0, 32'h0);
      check("t5_req_after_drop", 32'(imem_req), 32'd1);
      check("t5_addr_after_drop", imem_addr, 32'h100);
      repeat (6) cycle(1'b0, 1'b0, 32'h0);
      watch_dropped = 1'b0;
      check("t5_dropped_data_hidden", 32'(dropped_seen), 32'd0);

      // asynchronous reset in the middle of a wait
      cycle(1'b0, 1'b0, 32'h0);
      #2;
      reset = 1'b0; stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b1;
      #1;
      check("t6_req", 32'(imem_req), 32'd0);
      check("t6_addr", imem_addr, RESET_PC);
      check("t6_fv", 32'(fetch_valid), 32'd0);
      check("t6_instr", instruction, 32'd0);
      check("t6_npc", next_pc, 32'd0);
      check("t6_flush_hi", 32'(if_id_flush), 32'd1);
      branch_taken = 1'b0;
      #1;
      check("t6_flush_lo", 32'(if_id_flush), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      mem_k = 0;
      repeat (3) cycle(1'b0, 1'b0, 32'h0);
      check("t6_restart_instr", instruction, 32'hE000_0004);
      check("t6_restart_addr", imem_addr, 32'h8);

      // address wrap
      cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
      repeat (2) cycle(1'b0, 1'b0, 32'h0);
      check("t7_wrap_npc", next_pc, 32'h0);
      check("t7_wrap_addr", imem_addr, 32'h0);
      repeat (2) cycle(1'b0, 1'b0, 32'h0);

      // random traffic
      rand_mem = 1'b1;
      mem_k    = $urandom_range(0, 3);
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
